// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - borrow_in), LSB first, with valid/ready on both sides.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ai, bi, d_bit, bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSB pair and the running borrow.
    assign ai    = a_sh_q[0];
    assign bi    = b_sh_q[0];
    assign d_bit = ai ^ bi ^ borrow_q;
    assign bout  = (~ai & bi) | (~(ai ^ bi) & borrow_q);

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = borrow_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                res_d    = {d_bit, res_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = bout;
                if (cnt_q == LAST_BIT) begin
                    // Counter parks at WIDTH-1 rather than wrapping.
                    state_d = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = (ai ^ bi) & (ai ^ d_bit);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff       = res_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return W'(r);
    endfunction

    function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return int'(x) < (int'(y) + int'(c));
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = int'($signed(x)) - int'($signed(y)) - int'(c);
        return (r < -(1 << (W-1))) || (r > ((1 << (W-1)) - 1));
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin,
                          input logic [W-1:0] exp_d, input logic exp_b, input string name);
        int cycles;
        check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a = av; b = bv; borrow_in = bin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        check({name, " latency"}, 32'(cycles), 32'(W));
        check({name, " diff"}, 32'(diff), 32'(exp_d));
        check({name, " borrow_out"}, 32'(borrow_out), 32'(exp_b));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({name, " overflow"}, 32'(overflow), 32'(model_ovf(av, bv, bin)));
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " out_valid after accept"}, 32'(out_valid), 32'd0);
        check({name, " in_ready after accept"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[$];
        logic [W-1:0] ra, rb;
        logic         rc;

        vecs.push_back('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0});
        vecs.push_back('{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0});

        // Reset state
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow_out", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("reset overflow", 32'(overflow), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout,
                   $sformatf("vec%0d", i));

`ifdef SERIAL_SUB_OVERFLOW_EN
        // Signed overflow corners
        a = 8'h80; b = 8'h01; borrow_in = 1'b0; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        repeat (W) tick();
        check("ovf 80-01 overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        a = 8'h7F; b = 8'h01; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        repeat (W) tick();
        check("ovf 7F-01 overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif

        // Backpressure in DONE with ignored in_valid, then simultaneous out_ready/in_valid
        a = 8'h05; b = 8'h03; borrow_in = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'hAA; b = 8'h11;
        repeat (W) tick();
        check("bp out_valid at DONE", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp hold%0d diff", i), 32'(diff), 32'h02);
            check($sformatf("bp hold%0d borrow_out", i), 32'(borrow_out), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready (no bypass)", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp next accepted in_ready", 32'(in_ready), 32'd0);
        repeat (W) tick();
        check("bp next out_valid", 32'(out_valid), 32'd1);
        check("bp next diff", 32'(diff), 32'h99);
        check("bp next borrow_out", 32'(borrow_out), 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset in the middle of SHIFT (bit 3)
        a = 8'h55; b = 8'h22; borrow_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset diff", 32'(diff), 32'd0);
        check("midreset borrow_out", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "post-reset");

        // Random operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, model_diff(ra, rb, rc), model_borrow(ra, rb, rc), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
